instr_sequencer: RTL and testbench

Multi-cycle sequencer for the 8-bit core. It fetches instructions, plus the ADDI immediate byte, from a single shared memory port and holds the instruction register that feeds the combinational decoder. It steps each instruction through execute, memory and write-back states, and gates the decoder's write strobes so each fires exactly once per instruction. It sits between the decoder, the register file/ALU datapath and the unified instruction/data memory.

---
 rtl/project_pkg.sv | 40 ++++
 rtl/seq_stall_counter.sv | 34 +++
 rtl/instr_sequencer.sv | 152 +++++++++++++++
 tb/tb_instr_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/project_pkg.sv
//------------------------------------------------------------------------------
// Module : project_pkg
// Brief  : Shared types for the 8-bit core: data word, opcodes, sequencer states.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package project_pkg;

    typedef logic [7:0] word;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_ADDI = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_COPY = 4'h6,
        OP_LW   = 4'h7,
        OP_SW   = 4'h8,
        OP_RO   = 4'h9,
        OP_JEQ  = 4'hC
    } e_instr;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        IMM   = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4
    } e_seq_state;

    function automatic logic [3:0] opcode_of(input word w);
        return w[7:4];
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_stall_counter.sv
//------------------------------------------------------------------------------
// Module : seq_stall_counter
// Brief  : Saturating up-counter with enable and synchronous clear.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_stall_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != C_MAX)) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
//------------------------------------------------------------------------------
// Module : instr_sequencer
// Brief  : Multi-cycle FETCH/IMM/EXEC/MEM/WB sequencer over a shared memory port.
//          Optional stall counter enabled by macro SEQ_STALL_CNT_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_sequencer
    import project_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
`ifdef SEQ_STALL_CNT_EN
    ,
    parameter int         STALL_W  = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    output logic       mem_wr,
    input  logic       mem_ack,
    input  word        mem_rdata,
    input  word        data_addr,
    input  word        jump_target,
    input  logic       dec_reg_wr,
    input  logic       dec_mem_wr,
    input  logic       dec_mem_to_reg,
    input  logic       dec_pc_src,
    input  logic       dec_alu_src,
    output word        instr,
    output word        imm,
    output logic [7:0] pc,
    output logic       reg_wr_en,
    output word        load_data,
    output logic       wb_sel_mem
`ifdef SEQ_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    e_seq_state r_state;
    logic [7:0] r_pc;
    word        r_instr;
    word        r_imm;
    word        r_load;

    logic       w_mem_rd;
    logic       w_mem_wr;
    logic [7:0] w_mem_addr;
    logic       w_reg_wr_en;
    logic       w_wb_sel;
    logic       w_ack;
    logic       w_is_lw;
    logic       w_unused;

    // ALU source select is consumed by the datapath only.
    assign w_unused = dec_alu_src;
    assign w_is_lw  = (opcode_of(r_instr) == OP_LW);

    // Outputs follow the registered state; reset forces every strobe low at once.
    always_comb begin
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        w_mem_addr  = r_pc;
        w_reg_wr_en = 1'b0;
        w_wb_sel    = 1'b0;
        if (!rst) begin
            case (r_state)
                FETCH, IMM: w_mem_rd = 1'b1;
                EXEC:       w_reg_wr_en = dec_reg_wr && !w_is_lw;
                MEM: begin
                    w_mem_addr = data_addr;
                    w_mem_rd   = dec_mem_to_reg;
                    w_mem_wr   = dec_mem_wr && !dec_mem_to_reg;
                end
                WB: begin
                    w_reg_wr_en = 1'b1;
                    w_wb_sel    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_ack = (w_mem_rd || w_mem_wr) && mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_instr <= 8'h00;
            r_imm   <= 8'h00;
            r_load  <= 8'h00;
        end else begin
            case (r_state)
                FETCH: if (w_ack) begin
                    r_instr <= mem_rdata;
                    r_pc    <= r_pc + 8'd1;
                    r_state <= (opcode_of(mem_rdata) == OP_ADDI) ? IMM : EXEC;
                end
                IMM: if (w_ack) begin
                    r_imm   <= mem_rdata;
                    r_pc    <= r_pc + 8'd1;
                    r_state <= EXEC;
                end
                EXEC: begin
                    if (dec_pc_src) begin
                        r_pc <= jump_target;
                    end
                    r_state <= (w_is_lw || dec_mem_wr) ? MEM : FETCH;
                end
                MEM: if (w_ack) begin
                    if (w_is_lw) begin
                        r_load  <= mem_rdata;
                        r_state <= WB;
                    end else begin
                        r_state <= FETCH;
                    end
                end
                WB:      r_state <= FETCH;
                default: r_state <= FETCH;
            endcase
        end
    end

    assign mem_addr   = w_mem_addr;
    assign mem_rd     = w_mem_rd;
    assign mem_wr     = w_mem_wr;
    assign instr      = r_instr;
    assign imm        = r_imm;
    assign pc         = r_pc;
    assign reg_wr_en  = w_reg_wr_en;
    assign wb_sel_mem = w_wb_sel;
    assign load_data  = r_load;

`ifdef SEQ_STALL_CNT_EN
    seq_stall_counter #(
        .WIDTH (STALL_W)
    ) u_stall_counter (
        .clk     (clk),
        .rst     (rst),
        .i_en    ((w_mem_rd || w_mem_wr) && !mem_ack),
        .o_count (stall_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_instr_sequencer
// Brief  : Scoreboard bench for instr_sequencer (two instances: RESET_PC 00/FF).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_sequencer;
    import project_pkg::*;

    typedef struct packed {
        logic kind;   // 0 = accepted memory access, 1 = register write
        logic wr;
        word  addr;
        logic wbsel;
        word  ld;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, sel, jeq_take;
    logic mem_ack;
    word  mem_rdata, data_addr, jump_target;
    logic dec_reg_wr, dec_mem_wr, dec_mem_to_reg, dec_pc_src, dec_alu_src;

    word  mem_addr0, mem_addr1, instr0, instr1, imm0, imm1, pc0, pc1, ld0, ld1;
    logic mem_rd0, mem_rd1, mem_wr0, mem_wr1, rwe0, rwe1, wbs0, wbs1;
`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall0, stall1, m_stall;
`endif

    word  m_addr, m_instr, m_imm, m_pc, m_ld;
    logic m_rd, m_wr, m_rwe, m_wbs, m_req;

    word mem [256];
    int  data_wait, cur_wait, wcnt;
    int  total, bad;
    ev_t q[$];

    instr_sequencer #(.RESET_PC(8'h00)) u_dut0 (
        .clk(clk), .rst(rst0), .mem_addr(mem_addr0), .mem_rd(mem_rd0), .mem_wr(mem_wr0),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .data_addr(data_addr),
        .jump_target(jump_target), .dec_reg_wr(dec_reg_wr), .dec_mem_wr(dec_mem_wr),
        .dec_mem_to_reg(dec_mem_to_reg), .dec_pc_src(dec_pc_src), .dec_alu_src(dec_alu_src),
        .instr(instr0), .imm(imm0), .pc(pc0), .reg_wr_en(rwe0), .load_data(ld0),
        .wb_sel_mem(wbs0)
`ifdef SEQ_STALL_CNT_EN
        , .stall_cnt(stall0)
`endif
    );

    instr_sequencer #(.RESET_PC(8'hFF)) u_dut1 (
        .clk(clk), .rst(rst1), .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_wr(mem_wr1),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .data_addr(data_addr),
        .jump_target(jump_target), .dec_reg_wr(dec_reg_wr), .dec_mem_wr(dec_mem_wr),
        .dec_mem_to_reg(dec_mem_to_reg), .dec_pc_src(dec_pc_src), .dec_alu_src(dec_alu_src),
        .instr(instr1), .imm(imm1), .pc(pc1), .reg_wr_en(rwe1), .load_data(ld1),
        .wb_sel_mem(wbs1)
`ifdef SEQ_STALL_CNT_EN
        , .stall_cnt(stall1)
`endif
    );

    always_comb begin
        m_addr  = sel ? mem_addr1 : mem_addr0;
        m_rd    = sel ? mem_rd1   : mem_rd0;
        m_wr    = sel ? mem_wr1   : mem_wr0;
        m_instr = sel ? instr1    : instr0;
        m_imm   = sel ? imm1      : imm0;
        m_pc    = sel ? pc1       : pc0;
        m_ld    = sel ? ld1       : ld0;
        m_rwe   = sel ? rwe1      : rwe0;
        m_wbs   = sel ? wbs1      : wbs0;
`ifdef SEQ_STALL_CNT_EN
        m_stall = sel ? stall1    : stall0;
`endif
    end

    // Memory model: addresses at or above 0x40 take data_wait wait states.
    always_comb begin
        m_req     = m_rd | m_wr;
        cur_wait  = (m_addr >= 8'h40) ? data_wait : 0;
        mem_ack   = m_req && (wcnt >= cur_wait);
        mem_rdata = mem[m_addr];
    end

    always @(posedge clk) begin
        if (m_req && !mem_ack) wcnt <= wcnt + 1;
        else                   wcnt <= 0;
    end

    // Reference decoder for the selected instruction register.
    always_comb begin
        logic [3:0] op;
        op             = m_instr[7:4];
        dec_reg_wr     = (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9});
        dec_mem_wr     = (op == 4'h8);
        dec_mem_to_reg = (op == 4'h7);
        dec_pc_src     = (op == 4'hC) && jeq_take;
        dec_alu_src    = (op == 4'h2);
    end

    function automatic ev_t ev_mem(input logic wr, input word a);
        ev_t e;
        e = '0; e.kind = 1'b0; e.wr = wr; e.addr = a;
        return e;
    endfunction

    function automatic ev_t ev_reg(input logic s, input word d);
        ev_t e;
        e = '0; e.kind = 1'b1; e.wbsel = s; e.ld = d;
        return e;
    endfunction

    always @(negedge clk) begin
        ev_t a, e;
        logic have;
        have = 1'b0;
        a    = '0;
        if (m_req && mem_ack) begin
            a = ev_mem(m_wr, m_addr); have = 1'b1;
        end else if (m_rwe) begin
            a = ev_reg(m_wbs, m_wbs ? m_ld : 8'h00); have = 1'b1;
        end
        if (have) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got event %h, expected none", a);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL sb_event: got %h, expected %h", a, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset(input logic s, input word rpc);
        sel  = s;
        rst0 = 1'b1;
        rst1 = 1'b1;
        cyc(2);
        chk("rst_pc", m_pc, rpc);
        chk("rst_instr_imm", {m_instr, m_imm}, 16'h0000);
        chk("rst_strobes", {m_rd, m_wr, m_rwe, m_wbs}, 4'b0000);
`ifdef SEQ_STALL_CNT_EN
        chk("rst_stall", m_stall, 16'd0);
`endif
        if (s) rst1 = 1'b0;
        else   rst0 = 1'b0;
    endtask

    task automatic end_test(input string name);
        rst0 = 1'b1;
        rst1 = 1'b1;
        #1;
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0; jeq_take = 1'b0;
        data_wait = 0; data_addr = 8'h00; jump_target = 8'h00;
        clear_mem();

        // ADD, zero-wait
        mem[8'h00] = 8'h16;
        do_reset(1'b0, 8'h00);
        q.push_back(ev_mem(1'b0, 8'h00));
        q.push_back(ev_reg(1'b0, 8'h00));
        cyc(1);
        chk("add_instr", m_instr, 8'h16);
        chk("add_pc", m_pc, 8'h01);
        cyc(1);
        chk("add_pc_after", m_pc, 8'h01);
        end_test("add_drain");

        // ADDI with immediate
        clear_mem();
        mem[8'h00] = 8'h24; mem[8'h01] = 8'h5A;
        do_reset(1'b0, 8'h00);
        q.push_back(ev_mem(1'b0, 8'h00));
        q.push_back(ev_mem(1'b0, 8'h01));
        q.push_back(ev_reg(1'b0, 8'h00));
        cyc(2);
        chk("addi_imm", m_imm, 8'h5A);
        chk("addi_pc", m_pc, 8'h02);
        cyc(1);
        end_test("addi_drain");

        // LW with two wait states
        clear_mem();
        mem[8'h00] = 8'h70; mem[8'h40] = 8'hC3;
        data_addr = 8'h40; data_wait = 2;
        do_reset(1'b0, 8'h00);
        q.push_back(ev_mem(1'b0, 8'h00));
        q.push_back(ev_mem(1'b0, 8'h40));
        q.push_back(ev_reg(1'b1, 8'hC3));
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            chk("lw_req_held", {m_rd, m_wr, m_addr}, {1'b1, 1'b0, 8'h40});
            cyc(1);
        end
        chk("lw_wb", {m_rwe, m_wbs, m_ld}, {1'b1, 1'b1, 8'hC3});
        cyc(1);
`ifdef SEQ_STALL_CNT_EN
        chk("lw_stall", m_stall, 16'd2);
`endif
        end_test("lw_drain");
        data_wait = 0;

        // JEQ taken
        clear_mem();
        mem[8'h00] = 8'hC0; jump_target = 8'h20; jeq_take = 1'b1;
        do_reset(1'b0, 8'h00);
        q.push_back(ev_mem(1'b0, 8'h00));
        q.push_back(ev_mem(1'b0, 8'h20));
        cyc(2);
        chk("jeq_taken_pc", m_pc, 8'h20);
        cyc(1);
        end_test("jeq_taken_drain");

        // JEQ not taken
        jeq_take = 1'b0;
        do_reset(1'b0, 8'h00);
        q.push_back(ev_mem(1'b0, 8'h00));
        q.push_back(ev_mem(1'b0, 8'h01));
        cyc(2);
        chk("jeq_nt_pc", m_pc, 8'h01);
        cyc(1);
        end_test("jeq_nt_drain");

        // PC wrap across FETCH->IMM from RESET_PC=FF
        clear_mem();
        mem[8'hFF] = 8'h24; mem[8'h00] = 8'h5A;
        do_reset(1'b1, 8'hFF);
        q.push_back(ev_mem(1'b0, 8'hFF));
        q.push_back(ev_mem(1'b0, 8'h00));
        q.push_back(ev_reg(1'b0, 8'h00));
        cyc(2);
        chk("wrap_imm", m_imm, 8'h5A);
        chk("wrap_pc", m_pc, 8'h01);
        cyc(1);
        end_test("wrap_drain");

        // Reset asserted during an un-acked SW
        clear_mem();
        mem[8'h00] = 8'h80; data_addr = 8'h50; data_wait = 1;
        do_reset(1'b0, 8'h00);
        q.push_back(ev_mem(1'b0, 8'h00));
        cyc(2);
        chk("sw_req", {m_rd, m_wr, m_addr}, {1'b0, 1'b1, 8'h50});
        rst0 = 1'b1;
        #1;
        chk("sw_rst_drop", {m_rd, m_wr, m_rwe}, 3'b000);
        cyc(1);
        chk("sw_rst_pc", m_pc, 8'h00);
        q.push_back(ev_mem(1'b0, 8'h00));
        rst0 = 1'b0;
        #1;
        chk("sw_refetch", {m_rd, m_wr, m_addr}, {1'b1, 1'b0, 8'h00});
        cyc(1);
        end_test("sw_drain");
        data_wait = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
